// File: rtl/bcd_seg7_display.sv
// Converts a 16-bit unsigned value to five BCD digits with a one-step-per-cycle
// double-dabble engine and scans them onto a 5-digit multiplexed 7-segment display.
module bcd_seg7_display #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [6:0]  seg,
  output logic [4:0]  an,
  output logic [19:0] bcd_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t      state;
  logic [15:0] last_value;
  logic [15:0] bin;
  logic [19:0] acc;
  logic [19:0] acc_adj;
  logic [3:0]  iter;

  logic [PW-1:0] prescale;
  logic [2:0]    digit_sel;

  logic [4:0] blank;
  logic [3:0] nib;
  logic       blank_sel;
  logic [4:0] onehot;
  logic [6:0] pattern;

  // Add-3 correction applied to every nibble before each shift.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc[4*gi +: 4] >= 4'd5) ? acc[4*gi +: 4] + 4'd3
                                                            : acc[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_value <= '0;
      bin        <= '0;
      acc        <= '0;
      iter       <= '0;
      bcd_out    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (value != last_value) begin
            bin        <= value;
            acc        <= '0;
            last_value <= value;
            busy       <= 1'b1;
            iter       <= '0;
            state      <= CONV;
          end
        end
        CONV: begin
          {acc, bin} <= {acc_adj, bin} << 1;
          iter       <= iter + 4'd1;
          if (iter == 4'd15) state <= LATCH;
        end
        LATCH: begin
          bcd_out <= acc;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale  <= '0;
      digit_sel <= '0;
    end else if (prescale == PW'(SCAN_DIV - 1)) begin
      prescale  <= '0;
      digit_sel <= (digit_sel == 3'd4) ? 3'd0 : digit_sel + 3'd1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // A digit is blank when it and every more significant nibble are zero.
  assign blank[0] = 1'b0;
  generate
    for (gi = 1; gi < 5; gi++) begin : g_blank
      assign blank[gi] = (bcd_out[19:4*gi] == '0);
    end
  endgenerate

  always_comb begin
    nib       = 4'd0;
    blank_sel = 1'b0;
    onehot    = 5'b00000;
    case (digit_sel)
      3'd0: begin nib = bcd_out[3:0];   blank_sel = blank[0]; onehot = 5'b00001; end
      3'd1: begin nib = bcd_out[7:4];   blank_sel = blank[1]; onehot = 5'b00010; end
      3'd2: begin nib = bcd_out[11:8];  blank_sel = blank[2]; onehot = 5'b00100; end
      3'd3: begin nib = bcd_out[15:12]; blank_sel = blank[3]; onehot = 5'b01000; end
      3'd4: begin nib = bcd_out[19:16]; blank_sel = blank[4]; onehot = 5'b10000; end
      default: ;
    endcase
  end

  always_comb begin
    pattern = 7'b0000000;
    case (nib)
      4'd0: pattern = 7'b0111111;
      4'd1: pattern = 7'b0000110;
      4'd2: pattern = 7'b1011011;
      4'd3: pattern = 7'b1001111;
      4'd4: pattern = 7'b1100110;
      4'd5: pattern = 7'b1101101;
      4'd6: pattern = 7'b1111101;
      4'd7: pattern = 7'b0000111;
      4'd8: pattern = 7'b1111111;
      4'd9: pattern = 7'b1101111;
      default: pattern = 7'b0000000;
    endcase
    if (blank_sel) pattern = 7'b0000000;
  end

  assign seg = SEG_ACTIVE_LOW ? ~pattern : pattern;
  assign an  = AN_ACTIVE_LOW  ? ~onehot  : onehot;

endmodule

// File: tb/tb_bcd_seg7_display.sv
// Randomized scoreboard bench: expected BCD results are queued by the stimulus
// and checked by a monitor whenever a conversion completes (busy falls).
module tb_bcd_seg7_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'd0;
  logic [6:0]  seg;
  logic [4:0]  an;
  logic [19:0] bcd_out;
  logic        busy;

  logic [15:0] value4 = 16'd0;
  logic [6:0]  seg4;
  logic [4:0]  an4;
  logic [19:0] bcd_out4;
  logic        busy4;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int model_last = 0;
  int p10[5] = '{1, 10, 100, 1000, 10000};
  logic [6:0] seg_tbl[10];

  bcd_seg7_display #(.SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .value(value),
    .seg(seg), .an(an), .bcd_out(bcd_out), .busy(busy)
  );

  bcd_seg7_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut4 (
    .clk(clk), .reset(reset), .value(value4),
    .seg(seg4), .an(an4), .bcd_out(bcd_out4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Decimal digits packed as nibbles, straight from the arithmetic definition.
  function automatic int to_bcd(input int v);
    int r = 0;
    for (int k = 0; k < 5; k++) r += ((v / p10[k]) % 10) << (4 * k);
    return r;
  endfunction

  // Issue a new value; a conversion is expected only if it differs from the last one.
  task automatic apply(input int v);
    @(negedge clk);
    value = v[15:0];
    if (v != model_last) exp_q.push_back(to_bcd(v));
    model_last = v;
    $display("apply value=%0d expect_conv=%0d", v, exp_q.size());
  endtask

  // Five consecutive scan slots (SCAN_DIV=1) must show the digits of v in order.
  task automatic show_check(input int v);
    int idx;
    int prev_idx = -1;
    int exp_seg;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      idx = -1;
      for (int i = 0; i < 5; i++) if (an[i] == 1'b0) idx = i;
      check("an_onehot", $countones(~an), 1);
      if (idx >= 0) begin
        if (idx > 0 && v < p10[idx]) exp_seg = 7'h7F;
        else exp_seg = {25'd0, ~seg_tbl[(v / p10[idx]) % 10]};
        check("seg", {25'd0, seg}, exp_seg);
        if (prev_idx >= 0) check("scan_order", idx, (prev_idx + 1) % 5);
      end
      prev_idx = idx;
    end
  endtask

  // Monitor: busy falling edge marks a completed conversion.
  initial begin
    int cnt = 0;
    logic prev = 1'b0;
    int exp;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
        prev = 1'b0;
      end else begin
        if (busy) cnt++;
        else if (prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_conv: got bcd_out=%0h want no conversion", bcd_out);
          end else begin
            exp = exp_q.pop_front();
            check("bcd_out", {12'd0, bcd_out}, exp);
            check("busy_cycles", cnt, 17);
            $display("conv done bcd_out=%05h busy_cycles=%0d", bcd_out, cnt);
          end
          cnt = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin
    int v;
    int d;
    seg_tbl[0] = 7'b0111111; seg_tbl[1] = 7'b0000110; seg_tbl[2] = 7'b1011011;
    seg_tbl[3] = 7'b1001111; seg_tbl[4] = 7'b1100110; seg_tbl[5] = 7'b1101101;
    seg_tbl[6] = 7'b1111101; seg_tbl[7] = 7'b0000111; seg_tbl[8] = 7'b1111111;
    seg_tbl[9] = 7'b1101111;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_bcd", {12'd0, bcd_out}, 0);
    check("rst_an", {27'd0, an}, 5'b11110);
    check("rst_seg", {25'd0, seg}, 7'b1000000);
    reset = 1'b0;

    // SCAN_DIV=4 instance: each anode active for 4 cycles, value 0 shown on units only.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      d = ((k + 1) / 4) % 5;
      check("scan4_an", {27'd0, an4}, {27'd0, ~(5'b00001 << d)});
      check("scan4_seg", {25'd0, seg4}, (d == 0) ? 7'b1000000 : 7'h7F);
    end
    check("idle_busy", {31'd0, busy}, 0);
    show_check(0);

    apply(12345); repeat (20) @(negedge clk); show_check(12345);
    apply(65535); repeat (20) @(negedge clk); show_check(65535);
    apply(7);     repeat (20) @(negedge clk); show_check(7);
    apply(7);     repeat (20) @(negedge clk); show_check(7);

    // Value changes mid-conversion: 100 finishes first, 101 follows.
    apply(100);
    repeat (5) @(negedge clk);
    value = 16'd101;
    exp_q.push_back(to_bcd(101));
    model_last = 101;
    repeat (40) @(negedge clk);
    show_check(101);

    // Reset during a conversion of 999.
    apply(999);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    model_last = 0;
    #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_bcd", {12'd0, bcd_out}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(to_bcd(999));
    model_last = 999;
    @(negedge clk);
    check("restart_busy", {31'd0, busy}, 1);
    repeat (20) @(negedge clk);
    show_check(999);

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 99);
      else v = $urandom_range(0, 65535);
      if (n == 8) v = model_last;
      apply(v);
      repeat (20) @(negedge clk);
      show_check(v);
    end

    repeat (25) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg7_display.md
# bcd_seg7_display

Consumer of the 16-bit counter value produced by the up/down counter datapath. Converts the unsigned `value` into five BCD digits with a sequential double-dabble engine and drives a 5-digit, time-multiplexed seven-segment display with leading-zero blanking. Sits beside the counter in `top_system` and runs on the same clock, so the display follows every count change.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be ≥1.
- `SEG_ACTIVE_LOW`, 1: 1 means a lit segment is driven 0.
- `AN_ACTIVE_LOW`, 1: 1 means the selected anode is driven 0.

- `clk` input 1: single clock; all state is updated on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `value` input 16: unsigned value to display (counter `c_out`).
- `seg` output 7: segment drive; bit0=a through bit6=g.
- `an` output 5: digit enables; bit0 = units digit.
- `bcd_out` output 20: last converted value, 5 BCD nibbles; [3:0] = units.
- `busy` output 1: high while a conversion is in progress.

## Operation
- Conversion FSM states: IDLE, CONV, LATCH.
- **IDLE**
  - If `value != last_value`: capture `value` into the shift register, clear the BCD accumulator, set `last_value <= value`, `busy <= 1`, iteration counter `<= 0`, go to CONV.
  - Otherwise stay in IDLE.
- **CONV**, one double-dabble step per cycle:
  - Add 3 to each BCD nibble that is ≥5.
  - Shift {bcd, bin} left by 1.
  - Increment the iteration counter.
  - After the 16th step, go to LATCH.
- **LATCH**: `bcd_out <= accumulator`, `busy <= 0`, go to IDLE.
- `value` changes during CONV/LATCH are ignored until the FSM returns to IDLE. The latest `value` is then compared against `last_value`, so intermediate values may be skipped; only the final value is guaranteed to be displayed.
- Width rules:
  - Accumulator is 20 bits.
  - Maximum input 65535 gives `bcd_out = 0x65535`; no overflow is possible.
- **Scan**
  - Prescaler counts 0..`SCAN_DIV`-1 and then wraps.
  - On each wrap, `digit_sel` advances 0→1→2→3→4→0.
  - `an` is one-hot on `digit_sel`, polarity set by `AN_ACTIVE_LOW`.
- **Decode** of the selected nibble, shown here as active-high gfedcba:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Invert all bits when `SEG_ACTIVE_LOW`=1.
- **Leading-zero blanking**
  - Digit i (i≥1) is blank (all segments off) when nibbles i..4 of `bcd_out` are all zero.
  - Digit 0 is never blanked.
  - The anode still cycles through blanked digits.
- Display reads `bcd_out` only, so it never shows a partial conversion.

## Timing
- Reset values:
  - State IDLE, `last_value`=0, `bcd_out`=0, `busy`=0.
  - Prescaler 0, `digit_sel`=0.
  - With default parameters: `an`=5'b11110, `seg`=7'b1000000 (digit "0" on units).
- Conversion latency, with edge E0 the IDLE edge that detects the mismatch:
  - `busy` is high after E0.
  - CONV steps occur on E1..E16.
  - `bcd_out` is updated and `busy` falls after E17.
  - Total: 17 cycles of `busy`, 18 cycles from detection to display update.
- `value` held constant at E17 and later: no new conversion.
- `value` changed during busy: the new conversion is detected on the first IDLE edge, E18.
- Reset mid-conversion:
  - Aborts immediately and returns all registers to reset values.
  - If `value`≠0 after reset release, conversion starts on the first edge.
- `SCAN_DIV`=1: `digit_sel` advances every cycle.
- `SCAN_DIV`=N: `digit_sel` is held for exactly N cycles.
- `seg`/`an` are combinational from `digit_sel` and `bcd_out`, with no extra latency. Both change on the same edge.

## Test plan
- Reset released, `value`=0 → no conversion (`busy` stays 0), `bcd_out`=0x00000, units shows "0", digits 1–4 blank.
- `value`=12345 one cycle after reset → `busy` high for 17 cycles, `bcd_out`=0x12345; with `SCAN_DIV`=1, `an`/`seg` over 5 cycles show 5,4,3,2,1 for digits 0..4.
- `value`=65535 → `bcd_out`=0x65535 after 18 cycles; `value`=7 → `bcd_out`=0x00007, digits 1–4 segments all off (active-low 1111111), `an` still cycling.
- `value` 100 → 101 on the 5th busy cycle → first `bcd_out`=0x00100, then a second conversion starting at E18 gives 0x00101.
- Reset asserted mid-conversion of 999 with `value` held at 999 → immediate `busy`=0, `bcd_out`=0; after release, `bcd_out`=0x00999 after 18 cycles.
- `SCAN_DIV`=4, `value`=0 → each anode active exactly 4 cycles in order 0..4, wrapping back to 0 after 20 cycles.
